// File: rtl/riscv_test_monitor_if.sv
// Bundles the table-load, run-control, core-retirement and result signals of the
// retirement checker. The slave modport is the checker; the master modport is its driver.
interface riscv_test_monitor_if #(
    parameter int IDX_W = 5
);
    logic             START;
    logic [IDX_W-1:0] NUM_CHECKS;
    logic             TBL_WE;
    logic [IDX_W-1:0] TBL_ADDR;
    logic [31:0]      TBL_NUM;
    logic [31:0]      TBL_ANS;
    logic [31:0]      NUM_INST;
    logic [31:0]      OUTPUT_PORT;
    logic             HALT;
    logic             BUSY;
    logic             DONE;
    logic             TEST_PASS;
    logic             TEST_FAIL;
    logic [2:0]       FAIL_CODE;
    logic [IDX_W-1:0] FAIL_IDX;
    logic [31:0]      FAIL_VALUE;
    logic [31:0]      CYCLE_CNT;
    logic [IDX_W:0]   PASS_CNT;

    modport master (
        output START, NUM_CHECKS, TBL_WE, TBL_ADDR, TBL_NUM, TBL_ANS,
        output NUM_INST, OUTPUT_PORT, HALT,
        input  BUSY, DONE, TEST_PASS, TEST_FAIL, FAIL_CODE, FAIL_IDX,
        input  FAIL_VALUE, CYCLE_CNT, PASS_CNT
    );

    modport slave (
        input  START, NUM_CHECKS, TBL_WE, TBL_ADDR, TBL_NUM, TBL_ANS,
        input  NUM_INST, OUTPUT_PORT, HALT,
        output BUSY, DONE, TEST_PASS, TEST_FAIL, FAIL_CODE, FAIL_IDX,
        output FAIL_VALUE, CYCLE_CNT, PASS_CNT
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Retirement checker for the RISCV_TOP core: walks a table of (NUM_INST, OUTPUT_PORT)
// pairs in order as instructions retire and reports pass/fail, reason, cycles and matches.
module riscv_test_monitor #(
    parameter int NUM_TEST = 22,
    parameter int IDX_W    = 5,
    parameter int TIMEOUT  = 100000
) (
    input logic                 CLK,
    input logic                 RST,
    riscv_test_monitor_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_MISMATCH   = 3'd1,
        FC_SKIP       = 3'd2,
        FC_INCOMPLETE = 3'd3,
        FC_TIMEOUT    = 3'd4
    } fail_code_e;

    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT - 1);

    logic [31:0] tbl_num [NUM_TEST];
    logic [31:0] tbl_ans [NUM_TEST];

    state_e           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] num_checks, num_checks_nxt;
    logic [IDX_W-1:0] fail_idx, fail_idx_nxt;
    fail_code_e       fail_code, fail_code_nxt;
    logic [31:0]      fail_value, fail_value_nxt;
    logic [31:0]      cycle_cnt, cycle_cnt_nxt;
    logic [IDX_W:0]   pass_cnt, pass_cnt_nxt;

    logic             in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] idx_inc;
    logic [31:0]      cur_num;
    logic [31:0]      cur_ans;
    logic [31:0]      cycle_inc;

    // Once every entry is consumed the read port is parked on entry 0; its value is unused.
    assign in_range  = idx < num_checks;
    assign rd_idx    = in_range ? idx : '0;
    assign cur_num   = tbl_num[rd_idx];
    assign cur_ans   = tbl_ans[rd_idx];
    assign idx_inc   = idx + 1'b1;
    assign cycle_inc = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;

    // NOTE: the table has no reset; its contents survive RST and change only through writes.
    always_ff @(posedge CLK) begin
        if (bus.TBL_WE && state == S_IDLE && int'(bus.TBL_ADDR) < NUM_TEST) begin
            tbl_num[bus.TBL_ADDR] <= bus.TBL_NUM;
            tbl_ans[bus.TBL_ADDR] <= bus.TBL_ANS;
        end
    end

    always_comb begin
        // NOTE: every next value is defaulted to its current value first, so no path infers a latch.
        state_nxt      = state;
        idx_nxt        = idx;
        num_checks_nxt = num_checks;
        fail_idx_nxt   = fail_idx;
        fail_code_nxt  = fail_code;
        fail_value_nxt = fail_value;
        cycle_cnt_nxt  = cycle_cnt;
        pass_cnt_nxt   = pass_cnt;

        case (state)
            S_RUN: begin
                cycle_cnt_nxt = cycle_inc;
                if (in_range && bus.NUM_INST == cur_num) begin
                    if (bus.OUTPUT_PORT == cur_ans) begin
                        idx_nxt      = idx_inc;
                        pass_cnt_nxt = pass_cnt + 1'b1;
                        // HALT on a matching edge is judged against the advanced index.
                        if (bus.HALT) begin
                            if (idx_inc == num_checks) begin
                                state_nxt = S_PASS;
                            end else begin
                                state_nxt     = S_FAIL;
                                fail_code_nxt = FC_INCOMPLETE;
                                fail_idx_nxt  = idx_inc;
                            end
                        end
                    end else begin
                        state_nxt      = S_FAIL;
                        fail_code_nxt  = FC_MISMATCH;
                        fail_idx_nxt   = idx;
                        fail_value_nxt = bus.OUTPUT_PORT;
                    end
                end else if (in_range && bus.NUM_INST > cur_num) begin
                    state_nxt      = S_FAIL;
                    fail_code_nxt  = FC_SKIP;
                    fail_idx_nxt   = idx;
                    fail_value_nxt = bus.NUM_INST;
                end else if (bus.HALT) begin
                    if (idx == num_checks) begin
                        state_nxt = S_PASS;
                    end else begin
                        state_nxt     = S_FAIL;
                        fail_code_nxt = FC_INCOMPLETE;
                        fail_idx_nxt  = idx;
                    end
                end else if (cycle_cnt == LAST_CYCLE) begin
                    state_nxt     = S_FAIL;
                    fail_code_nxt = FC_TIMEOUT;
                    fail_idx_nxt  = idx;
                end
            end
            default: begin
                // IDLE, PASS and FAIL all launch a fresh run on START.
                if (bus.START) begin
                    state_nxt      = S_RUN;
                    num_checks_nxt = bus.NUM_CHECKS;
                    idx_nxt        = '0;
                    cycle_cnt_nxt  = '0;
                    pass_cnt_nxt   = '0;
                    fail_code_nxt  = FC_NONE;
                    fail_idx_nxt   = '0;
                    fail_value_nxt = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            idx        <= '0;
            num_checks <= '0;
            fail_idx   <= '0;
            fail_code  <= FC_NONE;
            fail_value <= '0;
            cycle_cnt  <= '0;
            pass_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            num_checks <= num_checks_nxt;
            fail_idx   <= fail_idx_nxt;
            fail_code  <= fail_code_nxt;
            fail_value <= fail_value_nxt;
            cycle_cnt  <= cycle_cnt_nxt;
            pass_cnt   <= pass_cnt_nxt;
        end
    end

    assign bus.BUSY       = (state == S_RUN);
    assign bus.DONE       = (state == S_PASS) || (state == S_FAIL);
    assign bus.TEST_PASS  = (state == S_PASS);
    assign bus.TEST_FAIL  = (state == S_FAIL);
    assign bus.FAIL_CODE  = fail_code;
    assign bus.FAIL_IDX   = fail_idx;
    assign bus.FAIL_VALUE = fail_value;
    assign bus.CYCLE_CNT  = cycle_cnt;
    assign bus.PASS_CNT   = pass_cnt;
endmodule
